btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Conditions the four raw board push-buttons before they reach hero-state and main-state logic.
//  Per button, it does three things:
//  - 2-FF synchronisation;
//  - counter debounce;
//  - rising-edge press pulses with auto-repeat.
//  It also resolves a single hero direction using most-recent-press priority.
//  Sits directly upstream of Hero_state (dir) and State_machine (pressing), clocked by clk_game.
// PARAMETERS
//  DB_CYCLES      1_000_000  consecutive stable cycles needed to accept a level change (>=1)
//  REPEAT_DELAY   25_000_000 cycles from initial press pulse to first repeat pulse; 0 disables repeat
//  REPEAT_PERIOD  5_000_000  cycles between later repeat pulses (>=1)
// PORTS
//  clk        in   1  game clock; all logic on rising edge
//  rst_n      in   1  synchronous, active-low reset
//  btn        in   4  raw asynchronous buttons; [0]=up [1]=down [2]=left [3]=right
//  btn_level  out  4  debounced button levels
//  btn_press  out  4  one-cycle pulses: initial press plus auto-repeats
//  dir        out  2  resolved direction: 00 up, 01 down, 10 left, 11 right
//  dir_valid  out  1  high while any btn_level bit is high
//  pressing   out  1  ^btn_level (odd number of buttons held)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//  - all sync flops, counters and outputs go to 0;
//  - any in-flight debounce or repeat count is discarded, with no pulse on exit;
//  - a button held through reset re-qualifies from scratch.
//  Sync: btn passes through 2 flops; debounce logic sees only the 2nd-stage value s[i].
//  Debounce, per channel with counter cnt of width $clog2(DB_CYCLES+1):
//  - s[i]==btn_level[i]: cnt<=0.
//  - Otherwise cnt increments; when it reaches DB_CYCLES-1, btn_level[i]<=s[i] and cnt<=0.
//  - Any glitch back to agreement clears cnt; there is no hysteresis beyond this.
//  - Latency: a clean edge on btn is reflected in btn_level exactly 2+DB_CYCLES edges after it is first sampled.
//  Press/repeat, per channel FSM IDLE -> HELD:
//  - IDLE: on a btn_level 0->1 transition, btn_press[i]=1 in that same cycle as btn_level rises
//    (registered alongside it); load rc=REPEAT_DELAY-1; go to HELD.
//  - HELD, btn_level=0: go to IDLE with no pulse; rc<=0.
//  - HELD, rc==0 and REPEAT_DELAY!=0: pulse btn_press[i]; rc<=REPEAT_PERIOD-1.
//  - HELD, otherwise: rc decrements.
//  - rc width = $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). Arithmetic is unsigned and never wraps below 0.
//  Direction:
//  - A register holds the last direction.
//  - Any btn_press initial (non-repeat) pulse sets dir to that index.
//  - Simultaneous initial presses: the lowest index wins.
//  - If the button owning dir releases while others stay held, dir falls back to the lowest-index
//    held button in the same cycle the release appears on btn_level.
//  - All released: dir holds its last value and dir_valid=0.
//  - Release of the owner and a new press in the same cycle: the new press wins.
//  All outputs are registered. There is no combinational path from btn to any output.
// STRUCTURE
//  Shared package fury_pkg: direction codes DIR_UP/DOWN/LEFT/RIGHT (2-bit) and NUM_BTN=4.
//  Sub-module btn_debounce_ch (sync + debounce + press/repeat FSM), instantiated 4x via generate.
//  Direction arbitration lives in the top of this block.
// TESTING  (bench params DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//  1. Debounce latency:
//     btn[0] 0->1 clean after reset
//     -> btn_level[0]=1 and btn_press[0]=1 exactly 6 edges later;
//        dir=00, dir_valid=1, pressing=1.
//  2. Glitch rejection:
//     btn[1] high 3 cycles, low 2, high 3, low
//     -> btn_level stays 0, no btn_press, dir_valid=0.
//  3. Auto-repeat:
//     hold btn[2] 40 cycles after qualification
//     -> pulses at t=0, 10, 15, 20, 25, 30, 35; none after release;
//        repeat with REPEAT_DELAY=0 -> only t=0.
//  4. Priority:
//     - press btn[3], then btn[0]
//       -> dir 11 then 00;
//     - release btn[0]
//       -> dir=11 same cycle;
//     - simultaneous qualify of btn[1] and btn[2]
//       -> dir=01; pressing=^btn_level checked every cycle.
//  5. Reset mid-operation:
//     - rst_n=0 for 1 cycle mid-debounce and mid-repeat with buttons held
//       -> all outputs 0 the next cycle;
//     - the held button re-presses 6 edges after rst_n=1, with no spurious pulse.

Source files
------------

// File: rtl/fury_pkg.sv
// Shared definitions for the push-button front end: button count,
// direction codes, per-channel press FSM states and a priority helper.
package fury_pkg;

   localparam int NUM_BTN = 4;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   // Press/repeat FSM state; HELD tracks "debounced level is high".
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } press_state_t;

   // Index of the lowest set bit; DIR_UP when no bit is set.
   function automatic logic [1:0] lowest_set(input logic [NUM_BTN-1:0] v);
      logic [1:0] idx;
      idx = DIR_UP;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, counter debounce and a
// press/auto-repeat FSM. Also exports the next-cycle level and the
// initial-press strobe so the top can register direction alongside.
//
// Handshake note: there is no valid/ready pair here; o_press is a
// single-cycle strobe that downstream logic must consume on the cycle it
// is high, and o_rise/o_level_nxt are combinational previews of the value
// o_press/o_level will take at the next rising edge.
module btn_debounce_ch
   import fury_pkg::*;
#(
   parameter int DB_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_level_nxt,
   output logic o_rise
);

   localparam int CNT_W  = $clog2(DB_CYCLES + 1);
   localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RC_W   = $clog2(RC_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DB_CYCLES - 1);
   // A zero delay disables repeat; load 0 instead of wrapping below zero.
   localparam logic [RC_W-1:0]  RC_FIRST   = (REPEAT_DELAY == 0) ? '0 : RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0]  RC_PERIOD  = RC_W'(REPEAT_PERIOD - 1);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_level;
   logic [CNT_W-1:0]  r_cnt;
   press_state_t      r_state;
   logic [RC_W-1:0]   r_rc;
   logic              r_press;

   logic              w_accept;
   logic              w_level_nxt;
   logic              w_rise;

   // Two flops to bring the asynchronous button into the clock domain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // The level flips on the DB_CYCLES-th consecutive disagreeing sample.
   assign w_accept    = (r_sync2 != r_level) && (r_cnt == CNT_LAST);
   assign w_level_nxt = w_accept ? r_sync2 : r_level;
   assign w_rise      = w_accept & r_sync2;

   // Debounce counter: any agreement clears it, acceptance reloads it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else if (r_sync2 == r_level) begin
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_level <= r_sync2;
         r_cnt   <= '0;
      end else begin
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   // Press/repeat FSM, stepped on the same edge the debounced level updates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rc    <= '0;
         r_press <= 1'b0;
      end else begin
         r_press <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_press <= 1'b1;
                  r_rc    <= RC_FIRST;
                  r_state <= ST_HELD;
               end
            end
            ST_HELD: begin
               if (!w_level_nxt) begin
                  r_state <= ST_IDLE;
                  r_rc    <= '0;
               end else if ((r_rc == '0) && (REPEAT_DELAY != 0)) begin
                  r_press <= 1'b1;
                  r_rc    <= RC_PERIOD;
               end else if (r_rc != '0) begin
                  r_rc    <= r_rc - RC_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_rc    <= '0;
            end
         endcase
      end
   end

   assign o_level     = r_level;
   assign o_press     = r_press;
   assign o_level_nxt = w_level_nxt;
   assign o_rise      = w_rise;

endmodule

// File: rtl/btn_conditioner.sv
// Four-button conditioner: per-channel sync/debounce/repeat plus a
// most-recent-press direction resolver. Every output is a flop.
module btn_conditioner
   import fury_pkg::*;
#(
   parameter int DB_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [1:0]         dir,
   output logic               dir_valid,
   output logic               pressing
);

   logic [NUM_BTN-1:0] w_level_nxt;
   logic [NUM_BTN-1:0] w_rise;
   logic [1:0]         w_dir_nxt;

   logic [1:0]         r_dir;
   logic               r_dir_valid;
   logic               r_pressing;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DB_CYCLES     (DB_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_btn       (btn[g]),
         .o_level     (btn_level[g]),
         .o_press     (btn_press[g]),
         .o_level_nxt (w_level_nxt[g]),
         .o_rise      (w_rise[g])
      );
   end

   // New initial presses win; otherwise fall back when the owner releases.
   always_comb begin
      w_dir_nxt = r_dir;
      if (|w_rise) begin
         w_dir_nxt = lowest_set(w_rise);
      end else if (!w_level_nxt[r_dir] && (|w_level_nxt)) begin
         w_dir_nxt = lowest_set(w_level_nxt);
      end
   end

   // Register direction and the level summaries alongside btn_level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dir       <= DIR_UP;
         r_dir_valid <= 1'b0;
         r_pressing  <= 1'b0;
      end else begin
         r_dir       <= w_dir_nxt;
         r_dir_valid <= |w_level_nxt;
         r_pressing  <= ^w_level_nxt;
      end
   end

   assign dir       = r_dir;
   assign dir_valid = r_dir_valid;
   assign pressing  = r_pressing;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings.
module tb_btn_conditioner;
  import fury_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;

  always #5 clk = ~clk;

  logic [3:0] btn_level, btn_press, nr_level, nr_press;
  logic [1:0] dir, nr_dir;
  logic       dir_valid, pressing, nr_valid, nr_pressing;

  btn_conditioner #(.DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .btn_level(btn_level), .btn_press(btn_press),
    .dir(dir), .dir_valid(dir_valid), .pressing(pressing)
  );

  btn_conditioner #(.DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(5)) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .btn_level(nr_level), .btn_press(nr_press),
    .dir(nr_dir), .dir_valid(nr_valid), .pressing(nr_pressing)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  exp_level = 4'b0000;
  int          since_change = 100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] nb);
    btn = nb;
    since_change = 0;
  endtask

  // Clean changes appear on btn_level on the 6th edge after the change.
  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      since_change++;
      if (since_change == 6) exp_level = btn;
      check({tag, "_level"}, btn_level, exp_level);
      check({tag, "_pressing"}, pressing, ^exp_level);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int saw_level, saw_press, saw_valid, nr_extra, other_press;

    // Reset state
    rst_n = 1'b0;
    btn   = 4'b0000;
    repeat (3) tick();
    check("rst_level", btn_level, 4'b0000);
    check("rst_press", btn_press, 4'b0000);
    check("rst_dir", dir, 2'b00);
    check("rst_valid", dir_valid, 1'b0);
    check("rst_pressing", pressing, 1'b0);
    rst_n = 1'b1;

    // 1. Debounce latency
    btn = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_level_early", btn_level, 4'b0000);
      check("t1_press_early", btn_press, 4'b0000);
    end
    tick();
    check("t1_level", btn_level, 4'b0001);
    check("t1_press", btn_press, 4'b0001);
    check("t1_dir", dir, 2'b00);
    check("t1_valid", dir_valid, 1'b1);
    check("t1_pressing", pressing, 1'b1);
    tick();
    check("t1_press_once", btn_press, 4'b0000);
    btn = 4'b0000;
    repeat (6) tick();
    check("t1_rel_level", btn_level, 4'b0000);
    check("t1_rel_valid", dir_valid, 1'b0);
    check("t1_rel_pressing", pressing, 1'b0);

    // 2. Glitch rejection: high 3, low 2, high 3, then low
    saw_level = 0; saw_press = 0; saw_valid = 0;
    for (int i = 0; i < 20; i++) begin
      btn = (i < 3 || (i >= 5 && i < 8)) ? 4'b0010 : 4'b0000;
      tick();
      if (btn_level != 4'b0000) saw_level++;
      if (btn_press != 4'b0000) saw_press++;
      if (dir_valid) saw_valid++;
    end
    check("t2_level", saw_level, 0);
    check("t2_press", saw_press, 0);
    check("t2_valid", saw_valid, 0);

    // 3. Auto-repeat on btn[2]
    btn = 4'b0100;
    t0 = -1;
    for (int k = 1; k <= 10 && t0 < 0; k++) begin
      tick();
      if (btn_press[2]) t0 = k;
    end
    check("t3_qual_edge", t0, 6);
    check("t3_dir", dir, 2'b10);
    check("t3_nr_first", nr_press, 4'b0100);
    exp_q = {32'd10, 32'd15, 32'd20, 32'd25, 32'd30, 32'd35};
    nr_extra = 0; other_press = 0;
    for (int t = 1; t <= 50; t++) begin
      if (t == 34) btn = 4'b0000;
      tick();
      if (btn_press[2])
        check("t3_pulse_time", t, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
      if ((btn_press & 4'b1011) != 4'b0000) other_press++;
      if (nr_press != 4'b0000) nr_extra++;
      if (t == 38) check("t3_level_held", btn_level, 4'b0100);
      if (t == 39) begin
        check("t3_level_rel", btn_level, 4'b0000);
        check("t3_valid_rel", dir_valid, 1'b0);
        check("t3_dir_hold", dir, 2'b10);
      end
    end
    check("t3_missing_pulses", exp_q.size(), 0);
    check("t3_other_press", other_press, 0);
    check("t3_nr_repeats", nr_extra, 0);

    // 4. Direction priority
    exp_level = 4'b0000;
    set_btn(4'b1000);
    run(8, "t4a");
    check("t4a_dir", dir, 2'b11);
    set_btn(4'b1001);
    run(8, "t4b");
    check("t4b_dir", dir, 2'b00);
    set_btn(4'b1000);
    run(5, "t4c");
    check("t4c_dir_before", dir, 2'b00);
    run(1, "t4d");
    check("t4d_dir_fallback", dir, 2'b11);
    set_btn(4'b1110);
    run(6, "t4e");
    check("t4e_dir_simul", dir, 2'b01);
    check("t4e_press_simul", btn_press & 4'b0111, 4'b0110);
    run(2, "t4f");

    // 5. Reset mid-debounce and mid-repeat
    set_btn(4'b1111);
    run(3, "t5a");
    rst_n = 1'b0;
    tick();
    check("t5_rst_level", btn_level, 4'b0000);
    check("t5_rst_press", btn_press, 4'b0000);
    check("t5_rst_dir", dir, 2'b00);
    check("t5_rst_valid", dir_valid, 1'b0);
    check("t5_rst_pressing", pressing, 1'b0);
    check("t5_rst_nr_level", nr_level, 4'b0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t5_no_spurious", btn_press, 4'b0000);
      check("t5_level_early", btn_level, 4'b0000);
    end
    tick();
    check("t5_repress", btn_press, 4'b1111);
    check("t5_level", btn_level, 4'b1111);
    check("t5_dir", dir, 2'b00);
    check("t5_valid", dir_valid, 1'b1);
    check("t5_pressing", pressing, 1'b0);
    check("t5_nr_repress", nr_press, 4'b1111);
    tick();
    check("t5_press_once", btn_press, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
